ex_mdu: RTL
===========

EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; legal values 8..64, even.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port mdu_op  input  3  operation code from mdu_pkg: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_NOP.
REQ-005 SHALL have port start  input  1  request strobe; mdu_op/src_a/src_b sampled when start=1 and busy=0.
REQ-006 SHALL have port flush  input  1  pipeline flush; aborts in-flight operation.
REQ-007 SHALL have port src_a  input  WIDTH  multiplicand/dividend/move source.
REQ-008 SHALL have port src_b  input  WIDTH  multiplier/divisor.
REQ-009 SHALL have port busy  output  1  operation in flight; new starts ignored.
REQ-010 SHALL have port done  output  1  one-cycle pulse; hi/lo hold the new result in that cycle.
REQ-011 SHALL have ports hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-012 SHALL implement FSM IDLE -> MUL or DIV (on accepted start) -> FIN -> IDLE.
REQ-013 SHALL set busy=1 in MUL, DIV and FIN, and busy=0 in IDLE.
REQ-014 SHALL update hi/lo only on the edge entering FIN; done=1 exactly in FIN.
REQ-015 SHALL, for MULT/MULTU/DIV/DIVU, take WIDTH iteration cycles: start accepted at cycle 0 -> done at cycle WIDTH+1.
REQ-016 SHALL compute MULT/MULTU as shift-add on magnitudes, one partial-product bit per cycle; {hi,lo} = full 2*WIDTH product, two's-complement sign applied in the final cycle for MULT.
REQ-017 SHALL compute DIV/DIVU as restoring division on magnitudes, one quotient bit per cycle; lo=quotient, hi=remainder.
REQ-018 SHALL give DIV a quotient truncated toward zero, with the remainder taking the dividend's sign.
REQ-019 SHALL handle divide by zero (both signednesses) as: lo=all ones, hi=src_a, same latency, no exception.
REQ-020 SHALL handle DIV of the most-negative value by -1 as: lo=most-negative value, hi=0.
REQ-021 SHALL, for MTHI/MTLO, write src_a to hi/lo at the next edge, with done=1 in the following cycle, busy=0 throughout, and no FSM transition.
REQ-022 SHALL ignore start while busy=1; MDU_NOP or start=0 leaves state unchanged.
REQ-023 SHALL, on flush=1 in any state, return to IDLE at the next edge with hi/lo unchanged and no done.
REQ-024 SHALL give flush priority over a simultaneous start.
REQ-025 SHALL give flush arriving in FIN no effect on the hi/lo already written.
REQ-026 SHALL latch operands at acceptance; src_a/src_b changes during the operation have no effect.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set FSM=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
REQ-028 SHALL give rst priority over flush and start, and abort any operation mid-iteration.

Configuration
REQ-029 SHALL honour macro MDU_FAST_MUL_EN: when defined, MULT/MULTU complete in one cycle (start at cycle 0 -> done at cycle 1, via FIN) using a combinational WIDTH x WIDTH product; DIV is unaffected.
REQ-030 SHALL, when MDU_FAST_MUL_EN is undefined, use the iterative multiply per REQ-015/REQ-016, with no multiplier primitive inferred.

Structure
REQ-031 SHALL place the mdu_op codes and the FSM state enum in package mdu_pkg, shared with the decoder.
REQ-032 SHALL implement the restoring-division datapath in sub-module ex_mdu_div (WIDTH parameter, magnitude inputs, quotient/remainder outputs, step enable).
REQ-033 SHALL keep sign handling and HI/LO in ex_mdu.

Verification (WIDTH=32)
REQ-034 SHALL cover MULT with src_a=0xFFFFFFFE (-2), src_b=0x00000003 -> done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 SHALL cover DIV with src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
REQ-036 SHALL cover DIV with src_a=0x80000000, src_b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 SHALL cover DIVU 100/7 started, flush at cycle 10 -> IDLE at cycle 11, no done, hi/lo keep prior values; a new MULTU 3*5 then gives lo=15.
REQ-038 SHALL cover rst at cycle 5 of a MULTU -> busy=0, hi=lo=0 next cycle; a start during busy is ignored (single done).
REQ-039 SHALL cover MTHI src_a=0x12345678 -> hi=0x12345678 after one edge, done the following cycle; with MDU_FAST_MUL_EN, MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at cycle 1, hi=0xFFFFFFFE, lo=0x00000001.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation codes, FSM states and a small decode helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIN
  } mdu_state_e;

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/ex_mdu_div.sv
// Restoring divider on unsigned magnitudes, one quotient bit per enabled step.
// o_quot/o_rem present the result of the step taken on the coming edge.
module ex_mdu_div
  #(parameter int WIDTH = 32)
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
  );

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  // Partial remainder stays below the divisor, so bit WIDTH of w_diff is a clean borrow flag.
  always_comb begin
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_dvs};
    if (!w_diff[WIDTH]) begin
      o_rem  = w_diff[WIDTH-1:0];
      o_quot = {r_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_rem  = w_shift[WIDTH-1:0];
      o_quot = {r_quo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      r_rem <= o_rem;
      r_quo <= o_quot;
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// Optional macro MDU_FAST_MUL_EN: single-cycle combinational multiply instead of shift-add.
module ex_mdu
  import mdu_pkg::*;
  #(parameter int WIDTH = 32)
  (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mdu_op,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
  );

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e r_state, w_state_nxt;
  mdu_op_e    w_op;

  logic [CW-1:0]      r_cnt;
  logic               r_mt_done;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_pneg;
  logic               r_qneg;
  logic               r_rneg;
  logic               r_dz;

  logic               w_is_mul, w_is_div, w_a_neg, w_b_neg, w_last, w_div_load, w_div_step;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo_mag, w_rem_mag, w_div_quo, w_div_rem;
  logic [2*WIDTH-1:0] w_acc_nxt, w_mul_res;
`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_mag, w_fast_prod;
`endif

  assign w_op     = mdu_op_e'(mdu_op);
  assign w_is_mul = (w_op == MDU_MULT) || (w_op == MDU_MULTU);
  assign w_is_div = (w_op == MDU_DIV)  || (w_op == MDU_DIVU);
  assign w_a_neg  = op_is_signed(w_op) && src_a[WIDTH-1];
  assign w_b_neg  = op_is_signed(w_op) && src_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -src_a : src_a;
  assign w_b_mag  = w_b_neg ? -src_b : src_b;
  assign w_last   = (r_cnt == LAST);

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_FIN) || r_mt_done;

  // Shift-add: the step on the final edge is folded in before the sign is applied.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_res = r_pneg ? -w_acc_nxt : w_acc_nxt;

`ifdef MDU_FAST_MUL_EN
  assign w_fast_mag  = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
  assign w_fast_prod = (w_a_neg ^ w_b_neg) ? -w_fast_mag : w_fast_mag;
`endif

  assign w_div_load = (r_state == ST_IDLE) && start && !flush && w_is_div;
  assign w_div_step = (r_state == ST_DIV) && !flush;

  ex_mdu_div #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_div_load),
    .i_step     (w_div_step),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_quot     (w_quo_mag),
    .o_rem      (w_rem_mag)
  );

  // Divide by zero forces an all-ones quotient; the remainder already equals the dividend.
  assign w_div_quo = r_dz ? '1 : (r_qneg ? -w_quo_mag : w_quo_mag);
  assign w_div_rem = r_rneg ? -w_rem_mag : w_rem_mag;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && w_is_mul) begin
`ifdef MDU_FAST_MUL_EN
            w_state_nxt = ST_FIN;
`else
            w_state_nxt = ST_MUL;
`endif
          end else if (start && w_is_div) begin
            w_state_nxt = ST_DIV;
          end
        end
        ST_MUL:  if (w_last) w_state_nxt = ST_FIN;
        ST_DIV:  if (w_last) w_state_nxt = ST_FIN;
        ST_FIN:  w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi        <= '0;
      lo        <= '0;
      r_cnt     <= '0;
      r_mt_done <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_pneg    <= 1'b0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      r_mt_done <= 1'b0;
      if (!flush) begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              case (w_op)
                MDU_MTHI: begin
                  hi        <= src_a;
                  r_mt_done <= 1'b1;
                end
                MDU_MTLO: begin
                  lo        <= src_a;
                  r_mt_done <= 1'b1;
                end
                MDU_MULT, MDU_MULTU: begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                  r_mplier <= w_b_mag;
                  r_acc    <= '0;
                  r_pneg   <= w_a_neg ^ w_b_neg;
                  r_cnt    <= '0;
`ifdef MDU_FAST_MUL_EN
                  {hi, lo} <= w_fast_prod;
`endif
                end
                MDU_DIV, MDU_DIVU: begin
                  r_qneg <= w_a_neg ^ w_b_neg;
                  r_rneg <= w_a_neg;
                  r_dz   <= (src_b == '0);
                  r_cnt  <= '0;
                end
                default: ;
              endcase
            end
          end
          ST_MUL: begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) {hi, lo} <= w_mul_res;
          end
          ST_DIV: begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              hi <= w_div_rem;
              lo <= w_div_quo;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
